store_buf: RTL and testbench
============================

STORE_BUF -- requirements
Module: store_buf

Interface
REQ-001 Parameter: DEPTH, 8, number of store entries (power of two).
REQ-002 Parameter: DEPTH_SEL, 3, pointer width, log2(DEPTH).
REQ-003 Widths ADDR_LEN=32, DATA_LEN=32 and SPECTAG_LEN=5 SHALL come from the shared constants header.
REQ-004 Clock and reset: reset is synchronous and active-high; the clock is clk.
REQ-005 Port list, one per line:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- prmiss  in  1  branch mispredict this cycle
- prsuccess  in  1  branch resolved correct this cycle
- prtag  in  SPECTAG_LEN  tag of the resolved branch
- specfixtag  in  SPECTAG_LEN  kill mask on prmiss
- st_we  in  1  executed store arrives from the ldst issue stage
- st_addr  in  ADDR_LEN  effective address
- st_data  in  DATA_LEN  store data
- st_spectag  in  SPECTAG_LEN  store speculation tag
- st_specbit  in  1  store is speculative
- full  out  1  no free entry
- com_num  in  2  stores committed by the ROB this cycle (0-2)
- mem_we  out  1  drain write strobe to data memory
- mem_addr  out  ADDR_LEN  drain address
- mem_data  out  DATA_LEN  drain data
- ld_addr  in  ADDR_LEN  load lookup address
- ld_hit  out  1  forwarding hit
- ld_data  out  DATA_LEN  forwarded data

Function
REQ-006 The block SHALL be a circular buffer with three pointers: head (oldest, next to drain), ctail (first uncommitted entry) and tail (next free entry).
- Counts: cnt = tail-head; ucnt = tail-ctail; both mod 2*DEPTH, using an extra wrap bit per pointer.
REQ-007 full SHALL be 1 when cnt==DEPTH.
REQ-008 When st_we=1, full=0 and prmiss=0, the store SHALL be written at tail with {addr, data, spectag, specbit}, and tail SHALL advance by 1.
REQ-009 A store presented with st_we while full=1 or prmiss=1 SHALL be dropped, with no state change.
REQ-010 com_num SHALL advance ctail by com_num. The ROB guarantees com_num<=ucnt; if com_num>ucnt, ctail SHALL saturate at tail.
REQ-011 An entry is committed when it lies between head and ctail. Drain:
- When head!=ctail, mem_we=1 and mem_addr/mem_data = entry[head], combinationally.
- head SHALL advance by 1 at the clock edge.
- Drain is one entry per cycle, with a single-cycle memory write and no backpressure.
REQ-012 On prmiss, every uncommitted entry with specbit=1 and (spectag & specfixtag)!=0 SHALL be killed.
- tail SHALL rewind to the oldest killed index.
- Killed entries are contiguous at the tail, because stores issue in order.
- Commit and drain SHALL proceed normally in the same cycle.
REQ-013 On prsuccess without prmiss, every entry with spectag==prtag SHALL have specbit cleared.
REQ-014 Load forwarding SHALL be combinational:
- ld_hit=1 if any live entry (head..tail-1), committed or not, has addr==ld_addr.
- ld_data SHALL come from the youngest matching entry.
- ld_hit=0 and ld_data=0 otherwise.
REQ-015 Simultaneous events in one cycle: write, commit and drain SHALL all take effect.
- A store written this cycle SHALL NOT be visible to ld_hit until the next cycle.
- An entry drained this cycle remains forwardable during that cycle.
REQ-016 Pointer wrap-around from DEPTH-1 to 0 SHALL toggle the pointer's wrap bit; full and empty are distinguished by the wrap bit.

Reset
REQ-017 On reset, head, ctail and tail SHALL be 0 and all specbits SHALL be 0.
- Outputs after reset: full=0, mem_we=0, ld_hit=0, ld_data=0, mem_addr=0, mem_data=0.
REQ-018 Reset SHALL override every other input in the same cycle. Entry payload storage does not require reset.

Verification
REQ-019 Scenario: write stores A=0x100/0x11 and B=0x104/0x22; com_num=2 -> next cycle mem_we=1 with 0x100/0x11, then 0x104/0x22, then mem_we=0.
REQ-020 Scenario: write 8 stores, no commit -> full=1; a 9th st_we is dropped; commit 1 -> one drain, then full=0.
REQ-021 Scenario: write 0x200/0x5, then 0x200/0x9 -> ld_addr=0x200 gives ld_hit=1, ld_data=0x9; ld_addr=0x204 gives ld_hit=0.
REQ-022 Scenario: stores with spectag 00001, 00010 and 00010 (specbit=1), uncommitted; prmiss with specfixtag=00010 -> tail rewinds by 2; only the first store can later commit and drain.
REQ-023 Scenario: prsuccess with prtag=00001, then prmiss with specfixtag=00001 -> the store survives.
REQ-024 Scenario: pointer wrap -> 12 write/commit/drain pairs with interleaved loads give correct drains and forwarding; reset asserted mid-stream -> all pointers 0 and mem_we=0 the next cycle.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared datapath widths for the load/store path.
package constants_pkg;
    parameter int ADDR_LEN    = 32;
    parameter int DATA_LEN    = 32;
    parameter int SPECTAG_LEN = 5;
endpackage

// File: rtl/store_buf.sv
// Circular store buffer: in-order commit, one drain per cycle, load forwarding and mispredict kill.
// Drain and forwarding are combinational from state; no backpressure, full drops new stores.
module store_buf
    import constants_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DEPTH_SEL = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] specfixtag,
    input  logic                   st_we,
    input  logic [ADDR_LEN-1:0]    st_addr,
    input  logic [DATA_LEN-1:0]    st_data,
    input  logic [SPECTAG_LEN-1:0] st_spectag,
    input  logic                   st_specbit,
    output logic                   full,
    input  logic [1:0]             com_num,
    output logic                   mem_we,
    output logic [ADDR_LEN-1:0]    mem_addr,
    output logic [DATA_LEN-1:0]    mem_data,
    input  logic [ADDR_LEN-1:0]    ld_addr,
    output logic                   ld_hit,
    output logic [DATA_LEN-1:0]    ld_data
);
    localparam int PW = DEPTH_SEL + 1;

    logic [PW-1:0]          head_q, head_d, ctail_q, ctail_d, tail_q, tail_d;
    logic [ADDR_LEN-1:0]    addr_q    [DEPTH];
    logic [ADDR_LEN-1:0]    addr_d    [DEPTH];
    logic [DATA_LEN-1:0]    data_q    [DEPTH];
    logic [DATA_LEN-1:0]    data_d    [DEPTH];
    logic [SPECTAG_LEN-1:0] spectag_q [DEPTH];
    logic [SPECTAG_LEN-1:0] spectag_d [DEPTH];
    logic [DEPTH-1:0]       specbit_q, specbit_d;

    logic [PW-1:0]        cnt, ucnt, ucnt_new, com_ext, com_adv, kill_ptr, ptr, tail_base;
    logic [DEPTH_SEL-1:0] fidx;
    logic                 drain, wr_en, kill_found;

    always_comb begin
        cnt    = tail_q - head_q;
        ucnt   = tail_q - ctail_q;
        full   = (cnt == PW'(DEPTH));
        drain  = (head_q != ctail_q);
        wr_en  = st_we & ~full & ~prmiss;
        mem_we   = drain;
        mem_addr = drain ? addr_q[head_q[DEPTH_SEL-1:0]] : '0;
        mem_data = drain ? data_q[head_q[DEPTH_SEL-1:0]] : '0;

        // Oldest uncommitted speculative store hit by the kill mask; everything younger dies too.
        kill_found = 1'b0;
        kill_ptr   = tail_q;
        ptr        = ctail_q;
        for (int i = 0; i < DEPTH; i++) begin
            ptr = ctail_q + PW'(i);
            if (!kill_found && (PW'(i) < ucnt) && specbit_q[ptr[DEPTH_SEL-1:0]] &&
                (|(spectag_q[ptr[DEPTH_SEL-1:0]] & specfixtag))) begin
                kill_found = 1'b1;
                kill_ptr   = ptr;
            end
        end

        tail_base = (prmiss && kill_found) ? kill_ptr : tail_q;
        tail_d    = tail_base + PW'(wr_en);
        ucnt_new  = tail_base - ctail_q;
        com_ext   = PW'(com_num);
        com_adv   = (com_ext > ucnt_new) ? ucnt_new : com_ext;
        ctail_d   = ctail_q + com_adv;
        head_d    = head_q + PW'(drain);
    end

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        spectag_d = spectag_q;
        specbit_d = specbit_q;
        if (prsuccess && !prmiss) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (spectag_q[i] == prtag) specbit_d[i] = 1'b0;
            end
        end
        if (wr_en) begin
            addr_d[tail_q[DEPTH_SEL-1:0]]    = st_addr;
            data_d[tail_q[DEPTH_SEL-1:0]]    = st_data;
            spectag_d[tail_q[DEPTH_SEL-1:0]] = st_spectag;
            specbit_d[tail_q[DEPTH_SEL-1:0]] = st_specbit;
        end
    end

    // Walk oldest to youngest over registered state so the last match is the youngest
    // and a store being written this cycle is not yet visible.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fidx    = head_q[DEPTH_SEL-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q[DEPTH_SEL-1:0] + DEPTH_SEL'(i);
            if ((PW'(i) < cnt) && (addr_q[fidx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fidx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            ctail_q   <= '0;
            tail_q    <= '0;
            specbit_q <= '0;
        end else begin
            head_q    <= head_d;
            ctail_q   <= ctail_d;
            tail_q    <= tail_d;
            specbit_q <= specbit_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        data_q    <= data_d;
        spectag_q <= spectag_d;
    end
endmodule

// File: tb/tb_store_buf.sv
// Store buffer bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_store_buf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, prmiss, prsuccess, st_we, st_specbit, full, mem_we, ld_hit;
    logic [4:0]  prtag, specfixtag, st_spectag;
    logic [31:0] st_addr, st_data, mem_addr, mem_data, ld_addr, ld_data;
    logic [1:0]  com_num;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
        logic        sb;
    } ent_t;

    ent_t q[$];   // live stores, oldest first
    int   ncom;   // committed prefix length of q

    always #5 clk = ~clk;

    store_buf #(.DEPTH(8), .DEPTH_SEL(3)) dut (
        .clk(clk), .reset(reset), .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
        .specfixtag(specfixtag), .st_we(st_we), .st_addr(st_addr), .st_data(st_data),
        .st_spectag(st_spectag), .st_specbit(st_specbit), .full(full), .com_num(com_num),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; prmiss = 0; prsuccess = 0; prtag = 0; specfixtag = 0;
        st_we = 0; st_addr = 0; st_data = 0; st_spectag = 0; st_specbit = 0;
        com_num = 0;
    endtask

    task automatic model_update();
        bit   old_full;
        int   old_ncom, k, c;
        ent_t e;
        old_full = (q.size() == DEPTH);
        old_ncom = ncom;
        if (reset) begin
            q.delete();
            ncom = 0;
            return;
        end
        if (prmiss) begin
            k = -1;
            for (int i = ncom; i < q.size(); i++)
                if (k < 0 && q[i].sb && ((q[i].tag & specfixtag) != 0)) k = i;
            if (k >= 0) while (q.size() > k) void'(q.pop_back());
        end else if (prsuccess) begin
            for (int i = 0; i < q.size(); i++)
                if (q[i].tag == prtag) q[i].sb = 0;
        end
        c = int'(com_num);
        if (c > q.size() - ncom) c = q.size() - ncom;
        ncom += c;
        if (old_ncom > 0) begin
            void'(q.pop_front());
            ncom--;
        end
        if (st_we && !old_full && !prmiss) begin
            e.addr = st_addr; e.data = st_data; e.tag = st_spectag; e.sb = st_specbit;
            q.push_back(e);
        end
    endtask

    // Inputs are already set (at negedge); check outputs, clock once, advance the model.
    task automatic step();
        logic        e_we, e_hit;
        logic [31:0] e_ma, e_md, e_ld;
        #1;
        e_we = (ncom > 0);
        e_ma = e_we ? q[0].addr : 32'h0;
        e_md = e_we ? q[0].data : 32'h0;
        e_hit = 0;
        e_ld  = 0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].addr == ld_addr) begin
                e_hit = 1;
                e_ld  = q[i].data;
            end
        chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        chk("mem_addr", mem_addr, e_ma);
        chk("mem_data", mem_data, e_md);
        chk("ld_hit", {31'b0, ld_hit}, {31'b0, e_hit});
        chk("ld_data", ld_data, e_ld);
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] tg, input logic sb);
        st_we = 1; st_addr = a; st_data = d; st_spectag = tg; st_specbit = sb;
        step();
    endtask

    task automatic do_reset();
        reset = 1;
        step();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        ld_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q.delete();
        ncom = 0;
        idle_inputs();
        #1;
        chk("rst_full", {31'b0, full}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_ld_hit", {31'b0, ld_hit}, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        @(negedge clk);

        // Two stores, commit both, drain in order.
        store(32'h100, 32'h11, 5'd0, 1'b0);
        store(32'h104, 32'h22, 5'd0, 1'b0);
        com_num = 2; step();
        #1 chk("drain_a", mem_addr, 32'h100);
        step();
        #1 chk("drain_b", mem_data, 32'h22);
        step();
        #1 chk("drain_done", {31'b0, mem_we}, 32'h0);
        step();

        // Fill to full, drop a ninth, commit one.
        for (int i = 0; i < DEPTH; i++) store(32'h300 + 32'(4 * i), 32'(i + 1), 5'd0, 1'b0);
        #1 chk("full8", {31'b0, full}, 32'h1);
        store(32'h3ff, 32'hdead, 5'd0, 1'b0);
        com_num = 1; step();
        step();
        #1 chk("unfull", {31'b0, full}, 32'h0);
        do_reset();

        // Youngest match forwards.
        store(32'h200, 32'h5, 5'd0, 1'b0);
        ld_addr = 32'h200; store(32'h200, 32'h9, 5'd0, 1'b0);
        ld_addr = 32'h200; #1 chk("fwd_young", ld_data, 32'h9);
        step();
        ld_addr = 32'h204; step();
        do_reset();

        // Mispredict kills the two tag-2 stores.
        store(32'h400, 32'h1, 5'b00001, 1'b1);
        store(32'h404, 32'h2, 5'b00010, 1'b1);
        store(32'h408, 32'h3, 5'b00010, 1'b1);
        prmiss = 1; specfixtag = 5'b00010; step();
        com_num = 2; step();
        #1 chk("kill_drain", mem_addr, 32'h400);
        step();
        #1 chk("kill_empty", {31'b0, mem_we}, 32'h0);
        step();

        // Resolved branch protects its store from a later kill.
        store(32'h500, 32'h7, 5'b00001, 1'b1);
        prsuccess = 1; prtag = 5'b00001; step();
        prmiss = 1; specfixtag = 5'b00001; step();
        ld_addr = 32'h500; #1 chk("survive", {31'b0, ld_hit}, 32'h1);
        com_num = 1; step();
        step();

        // Wrap: write/commit/drain pairs with loads.
        for (int i = 0; i < 12; i++) begin
            ld_addr = 32'h600 + 32'(4 * ((i + 7) % 8));
            store(32'h600 + 32'(4 * (i % 8)), 32'h1000 + 32'(i), 5'd0, 1'b0);
            com_num = 1; ld_addr = 32'h600 + 32'(4 * (i % 8)); step();
        end

        // Random traffic with occasional mid-stream reset.
        for (int n = 0; n < 4000; n++) begin
            st_we      = ($urandom_range(0, 3) != 0);
            st_addr    = 32'h100 + 32'(4 * $urandom_range(0, 7));
            st_data    = $urandom;
            st_spectag = 5'(1 << $urandom_range(0, 4));
            st_specbit = $urandom_range(0, 1) == 1;
            com_num    = 2'($urandom_range(0, 2));
            prmiss     = ($urandom_range(0, 15) == 0);
            specfixtag = 5'($urandom);
            prsuccess  = ($urandom_range(0, 7) == 0);
            prtag      = 5'(1 << $urandom_range(0, 4));
            ld_addr    = 32'h100 + 32'(4 * $urandom_range(0, 7));
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
